// File: rtl/ascon_perm_core.sv
// Self-sequencing Ascon permutation engine: accepts a 320-bit state plus a round
// count, runs UNROLL rounds per clock and returns the result over valid/ready.
module ascon_perm_core #(
   parameter int UNROLL = 1,
   parameter int RND_W  = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear_i,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   input  logic [319:0]     state_i,
   input  logic [RND_W-1:0] rounds_i,
   output logic             out_valid_o,
   input  logic             out_ready_i,
   output logic [319:0]     state_o,
   output logic             busy_o,
   output logic             err_o
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_t;

   fsm_t         st_q, st_d;
   logic [319:0] state_q, state_d;
   logic [319:0] stage0, stage1;
   logic [3:0]   rnd_q, rnd_d, rnd_step, n_clamp;
   logic         err_q, err_d;
   logic         accept, last_rnd, over12;

   generate
      if (UNROLL != 1 && UNROLL != 2) begin : g_bad_unroll
         $error("ascon_perm_core: UNROLL must be 1 or 2");
      end
      if (RND_W < 4) begin : g_bad_rnd_w
         $error("ascon_perm_core: RND_W must be at least 4");
      end
   endgenerate

   function automatic logic [63:0] ror64(input logic [63:0] x, input int unsigned n);
      return (x >> n) | (x << (64 - n));
   endfunction

   // One full Ascon round: constant addition, bitsliced S-box, linear diffusion.
   function automatic logic [319:0] ascon_round(input logic [319:0] s, input logic [3:0] r);
      logic [63:0] x0, x1, x2, x3, x4;
      logic [63:0] t0, t1, t2, t3, t4;
      x0 = s[319:256];
      x1 = s[255:192];
      x2 = s[191:128];
      x3 = s[127:64];
      x4 = s[63:0];
      x2 = x2 ^ {56'd0, 4'hF - r, r};
      x0 = x0 ^ x4;
      x4 = x4 ^ x3;
      x2 = x2 ^ x1;
      t0 = ~x0 & x1;
      t1 = ~x1 & x2;
      t2 = ~x2 & x3;
      t3 = ~x3 & x4;
      t4 = ~x4 & x0;
      x0 = x0 ^ t1;
      x1 = x1 ^ t2;
      x2 = x2 ^ t3;
      x3 = x3 ^ t4;
      x4 = x4 ^ t0;
      x1 = x1 ^ x0;
      x0 = x0 ^ x4;
      x3 = x3 ^ x2;
      x2 = ~x2;
      x0 = x0 ^ ror64(x0, 19) ^ ror64(x0, 28);
      x1 = x1 ^ ror64(x1, 61) ^ ror64(x1, 39);
      x2 = x2 ^ ror64(x2, 1)  ^ ror64(x2, 6);
      x3 = x3 ^ ror64(x3, 10) ^ ror64(x3, 17);
      x4 = x4 ^ ror64(x4, 7)  ^ ror64(x4, 41);
      return {x0, x1, x2, x3, x4};
   endfunction

   assign over12     = rounds_i > RND_W'(12);
   assign n_clamp    = over12 ? 4'd12 : rounds_i[3:0];
   assign in_ready_o = (st_q == IDLE) || ((st_q == DONE) && out_ready_i);
   assign accept     = in_valid_i && in_ready_o;

   // Round datapath; the second stage is bypassed when only round 11 remains.
   always_comb begin
      stage0   = ascon_round(state_q, rnd_q);
      stage1   = stage0;
      rnd_step = rnd_q + 4'd1;
      last_rnd = (rnd_q >= 4'd11);
      if (UNROLL == 2 && rnd_q < 4'd11) begin
         stage1   = ascon_round(stage0, rnd_q + 4'd1);
         rnd_step = rnd_q + 4'd2;
         last_rnd = (rnd_q >= 4'd10);
      end
   end

   always_comb begin
      st_d    = st_q;
      state_d = state_q;
      rnd_d   = rnd_q;
      err_d   = err_q;
      if (clear_i) begin
         st_d  = IDLE;
         rnd_d = 4'd0;
      end else begin
         case (st_q)
            RUN: begin
               state_d = stage1;
               rnd_d   = rnd_step;
               if (last_rnd) st_d = DONE;
            end
            IDLE, DONE: begin
               if (st_q == DONE && out_ready_i) st_d = IDLE;
               if (accept) begin
                  state_d = state_i;
                  rnd_d   = 4'd12 - n_clamp;
                  st_d    = (n_clamp == 4'd0) ? DONE : RUN;
                  if (over12) err_d = 1'b1;
               end
            end
            default: st_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         st_q    <= IDLE;
         state_q <= '0;
         rnd_q   <= 4'd0;
         err_q   <= 1'b0;
      end else begin
         st_q    <= st_d;
         state_q <= state_d;
         rnd_q   <= rnd_d;
         err_q   <= err_d;
      end
   end

   assign out_valid_o = (st_q == DONE);
   assign busy_o      = (st_q == RUN);
   assign state_o     = state_q;
   assign err_o       = err_q;

endmodule
